// File: rtl/rv32i_ldst_ctrl.sv
// rtl/rv32i_ldst_ctrl.sv - RV32I load/store sequencer between ALU stage and data-memory bus
//
// Accepts one load/store request per instruction, rejects misaligned or illegal-width accesses,
// runs a held-request/ack memory access with byte lanes, stalls the pipeline while the access is
// outstanding and returns the sign/zero-extended load result as a one-cycle writeback pulse.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   i_load, i_store      one-cycle request qualifiers (load wins when both are set)
//   i_ld_st_width        0=byte 1=half 2=word 3=illegal
//   i_ld_unsigned        zero-extend load result
//   i_addr, i_st_data    effective byte address, right-justified store data
//   i_rd                 load destination register
//   o_stall              hold pipeline (combinational)
//   o_mem_*              word address, read/write strobes, byte enables, lane-replicated wdata
//   i_mem_rdata/ack      read data and access-complete from memory
//   o_wb_valid/rd/val    load writeback pulse, register index and value
//   o_misaligned         pulse when a request is rejected, o_bad_addr holds its address
//   o_bus_err            pulse when an access times out
`timescale 1ns/1ps
module rv32i_ldst_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [1:0]  i_ld_st_width,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_val,
  output logic        o_misaligned,
  output logic [31:0] o_bad_addr,
  output logic        o_bus_err
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Counter value on the last permitted non-ack cycle.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t        r_state;
  logic          r_mem_rd, r_mem_wr;
  logic [31:0]   r_mem_addr, r_mem_wdata;
  logic [3:0]    r_mem_be;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd, r_rd;
  logic [31:0]   r_wb_val, r_bad_addr;
  logic          r_misaligned, r_bus_err;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_lane, r_width;
  logic          r_unsigned;

  logic          w_req, w_aligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_lane_data, w_load_val;

  assign w_req = (r_state == S_IDLE) & (i_load | i_store);

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = i_st_data;
    case (i_ld_st_width)
      2'd0: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << i_addr[1:0];
        w_wdata   = {4{i_st_data[7:0]}};
      end
      2'd1: begin
        w_aligned = ~i_addr[0];
        w_be      = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{i_st_data[15:0]}};
      end
      2'd2: w_aligned = (i_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign w_lane_data = i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    case (r_width)
      2'd0:    w_load_val = {{24{w_lane_data[7] & ~r_unsigned}}, w_lane_data[7:0]};
      2'd1:    w_load_val = {{16{w_lane_data[15] & ~r_unsigned}}, w_lane_data[15:0]};
      default: w_load_val = i_mem_rdata;
    endcase
  end

  // Low in the ack cycle so the next instruction can advance on that edge.
  assign o_stall = (w_req & w_aligned) | ((r_state == S_ACCESS) & ~i_mem_ack);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_val     <= '0;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
      r_bus_err    <= 1'b0;
      r_cnt        <= '0;
      r_lane       <= '0;
      r_width      <= '0;
      r_unsigned   <= 1'b0;
      r_rd         <= '0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_wb_valid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_aligned) begin
              r_state     <= S_ACCESS;
              r_mem_rd    <= i_load;
              r_mem_wr    <= ~i_load;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_lane      <= i_addr[1:0];
              r_width     <= i_ld_st_width;
              r_unsigned  <= i_ld_unsigned;
              r_rd        <= i_rd;
              r_cnt       <= '0;
            end else begin
              r_misaligned <= 1'b1;
              r_bad_addr   <= i_addr;
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ack) begin
            // Ack takes priority over a timeout on the same cycle.
            r_state  <= S_IDLE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_mem_rd) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_val   <= w_load_val;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT)) begin
            r_state   <= S_IDLE;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd     = r_mem_rd;
  assign o_mem_wr     = r_mem_wr;
  assign o_mem_be     = r_mem_be;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_val     = r_wb_val;
  assign o_misaligned = r_misaligned;
  assign o_bad_addr   = r_bad_addr;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_rv32i_ldst_ctrl.sv
// tb/tb_rv32i_ldst_ctrl.sv - randomized, model-checked bench for rv32i_ldst_ctrl
`timescale 1ns/1ps
module tb_rv32i_ldst_ctrl;

  localparam int T  = 16;
  localparam int NC = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_load, i_store, i_ld_unsigned, i_mem_ack;
  logic [1:0]  i_ld_st_width;
  logic [31:0] i_addr, i_st_data, i_mem_rdata;
  logic [4:0]  i_rd;
  logic        o_stall, o_mem_rd, o_mem_wr, o_wb_valid, o_misaligned, o_bus_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_wb_val, o_bad_addr;
  logic [3:0]  o_mem_be;
  logic [4:0]  o_wb_rd;

  always #5 clk = ~clk;

  rv32i_ldst_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .i_load(i_load), .i_store(i_store),
    .i_ld_st_width(i_ld_st_width), .i_ld_unsigned(i_ld_unsigned), .i_addr(i_addr),
    .i_st_data(i_st_data), .i_rd(i_rd), .o_stall(o_stall), .o_mem_addr(o_mem_addr),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
    .o_wb_val(o_wb_val), .o_misaligned(o_misaligned), .o_bad_addr(o_bad_addr), .o_bus_err(o_bus_err)
  );

  // Expected outputs per cycle; an all-zero entry means "idle, nothing happening".
  typedef struct {
    bit        stall, rd, wr, chk_bus, wbv, mis, berr, rst;
    bit [31:0] addr, wdata, wbval, bad;
    bit [3:0]  be;
    bit [4:0]  wbrd;
  } exp_t;

  exp_t ex [NC];
  exp_t ce;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  bit   chk_en = 1'b0;
  bit [31:0] model_bad = 0;

  int n_rd, n_wr, n_stall, n_wb, n_mis, n_berr;
  logic [31:0] last_wb, last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, expv);
    end
  endtask

  function automatic bit model_aligned(input bit [1:0] w, input bit [31:0] a);
    case (w)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [3:0] model_be(input bit [1:0] w, input bit [31:0] a);
    bit [31:0] m;
    case (w)
      2'd0:    m = 32'd1 << (a % 4);
      2'd1:    m = 32'd3 << (a % 4);
      default: m = 32'hF;
    endcase
    return m[3:0];
  endfunction

  function automatic bit [31:0] model_wdata(input bit [1:0] w, input bit [31:0] sd);
    case (w)
      2'd0:    return (sd & 32'hFF) * 32'h01010101;
      2'd1:    return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic bit [31:0] model_load(input bit [1:0] w, input bit uns, input bit [31:0] a,
                                           input bit [31:0] rdata);
    bit [31:0] v;
    v = rdata >> (8 * (a % 4));
    case (w)
      2'd0: begin
        v = v & 32'hFF;
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Single compare process: DUT outputs against the model timeline, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      ce = ex[cyc];
      if (ce.rst) begin
        model_bad = 0;
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_be", {28'h0, o_mem_be}, 32'h0);
        chk("rst_wdata", o_mem_wdata, 32'h0);
        chk("rst_wb_rd", {27'h0, o_wb_rd}, 32'h0);
        chk("rst_wb_val", o_wb_val, 32'h0);
      end
      if (ce.mis) model_bad = ce.bad;
      chk("stall", {31'h0, o_stall}, {31'h0, ce.stall});
      chk("mem_rd", {31'h0, o_mem_rd}, {31'h0, ce.rd});
      chk("mem_wr", {31'h0, o_mem_wr}, {31'h0, ce.wr});
      chk("wb_valid", {31'h0, o_wb_valid}, {31'h0, ce.wbv});
      chk("misaligned", {31'h0, o_misaligned}, {31'h0, ce.mis});
      chk("bus_err", {31'h0, o_bus_err}, {31'h0, ce.berr});
      chk("bad_addr", o_bad_addr, model_bad);
      if (ce.chk_bus) begin
        chk("mem_addr", o_mem_addr, ce.addr);
        chk("mem_be", {28'h0, o_mem_be}, {28'h0, ce.be});
        chk("mem_wdata", o_mem_wdata, ce.wdata);
      end
      if (ce.wbv) begin
        chk("wb_rd", {27'h0, o_wb_rd}, {27'h0, ce.wbrd});
        chk("wb_val", o_wb_val, ce.wbval);
      end
      if (o_mem_rd) n_rd++;
      if (o_mem_wr) n_wr++;
      if (o_mem_rd || o_mem_wr) begin
        last_be    = o_mem_be;
        last_wdata = o_mem_wdata;
      end
      if (o_stall) n_stall++;
      if (o_wb_valid) begin
        n_wb++;
        last_wb = o_wb_val;
      end
      if (o_misaligned) n_mis++;
      if (o_bus_err) n_berr++;
    end
  end

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_stall = 0; n_wb = 0; n_mis = 0; n_berr = 0;
    last_wb = '0; last_wdata = '0; last_be = '0;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      i_mem_ack   = noise ? 1'($urandom % 2) : 1'b0;
      i_mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    i_mem_ack = 1'b0;
  endtask

  // Present one request now; d = wait cycles before ack (>= T means never), rst_at >= 0 pulls
  // reset on that access cycle instead of completing.
  task automatic run_txn(input bit ld, input bit st, input bit [1:0] w, input bit uns,
                         input bit [31:0] a, input bit [31:0] sd, input bit [4:0] rd,
                         input int d, input int rst_at, input bit [31:0] rdata);
    int c, last;
    bit ackc, toc, rstc;
    c = cyc;
    if (c + T + 8 >= NC) begin
      $display("FAIL cycle_budget cyc=%0d actual=%0d required=<%0d", c, c + T + 8, NC);
      $fatal(1);
    end
    i_load = ld; i_store = st; i_ld_st_width = w; i_ld_unsigned = uns;
    i_addr = a; i_st_data = sd; i_rd = rd; i_mem_ack = 1'b0;
    if (!model_aligned(w, a)) begin
      ex[c+1].mis = 1'b1;
      ex[c+1].bad = a;
      @(posedge clk); #1;
      i_load = 1'b0; i_store = 1'b0;
      return;
    end
    rstc = (rst_at >= 0);
    ackc = !rstc && (d < T);
    toc  = !rstc && (d >= T);
    last = rstc ? rst_at : (ackc ? d : T - 1);
    ex[c].stall = 1'b1;
    for (int k = 0; k <= last; k++) begin
      ex[c+1+k].rd      = ld;
      ex[c+1+k].wr      = !ld;
      ex[c+1+k].chk_bus = 1'b1;
      ex[c+1+k].addr    = a & 32'hFFFF_FFFC;
      ex[c+1+k].be      = model_be(w, a);
      ex[c+1+k].wdata   = model_wdata(w, sd);
      ex[c+1+k].stall   = !(ackc && k == d);
    end
    if (ackc && ld) begin
      ex[c+2+d].wbv   = 1'b1;
      ex[c+2+d].wbrd  = rd;
      ex[c+2+d].wbval = model_load(w, uns, a, rdata);
    end
    if (toc) ex[c+1+T].berr = 1'b1;
    if (rstc) ex[c+2+rst_at].rst = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      i_load = 1'b0; i_store = 1'b0;
      i_addr = $urandom; i_st_data = $urandom; i_rd = 5'($urandom);
      i_ld_st_width = 2'($urandom); i_ld_unsigned = 1'($urandom);
      i_mem_ack   = ackc && (k == d);
      i_mem_rdata = i_mem_ack ? rdata : $urandom;
      reset_n     = !(rstc && k == rst_at);
    end
    @(posedge clk); #1;
    i_mem_ack = 1'b0; reset_n = 1'b1; i_mem_rdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    bit ld, st, uns;
    bit [1:0] w;
    bit [31:0] a;
    int d, ra;
    reset_n = 1'b0; i_load = 1'b0; i_store = 1'b0; i_ld_st_width = '0; i_ld_unsigned = 1'b0;
    i_addr = '0; i_st_data = '0; i_rd = '0; i_mem_rdata = '0; i_mem_ack = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'h0, o_stall}, 32'h0);
    chk("reset_mem_rd", {31'h0, o_mem_rd}, 32'h0);
    chk("reset_mem_wr", {31'h0, o_mem_wr}, 32'h0);
    chk("reset_mem_be", {28'h0, o_mem_be}, 32'h0);
    chk("reset_mem_addr", o_mem_addr, 32'h0);
    chk("reset_mem_wdata", o_mem_wdata, 32'h0);
    chk("reset_wb_valid", {31'h0, o_wb_valid}, 32'h0);
    chk("reset_wb_rd", {27'h0, o_wb_rd}, 32'h0);
    chk("reset_wb_val", o_wb_val, 32'h0);
    chk("reset_misaligned", {31'h0, o_misaligned}, 32'h0);
    chk("reset_bad_addr", o_bad_addr, 32'h0);
    chk("reset_bus_err", {31'h0, o_bus_err}, 32'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(2, 1'b0);

    clear_counts();
    run_txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 5'd7, 3, -1, 32'hDEADBEEF);
    idle(2, 1'b0);
    chk("lw_be", {28'h0, last_be}, 32'hF);
    chk("lw_stall_cycles", n_stall, 4);
    chk("lw_wb_val", last_wb, 32'hDEADBEEF);
    chk("lw_wb_count", n_wb, 1);

    clear_counts();
    run_txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd3, 1, -1, 32'h80112233);
    idle(2, 1'b0);
    chk("lb_be", {28'h0, last_be}, 32'h8);
    chk("lb_wb_val", last_wb, 32'hFFFFFF80);
    clear_counts();
    run_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd0, 0, -1, 32'h80112233);
    idle(2, 1'b0);
    chk("lbu_wb_val", last_wb, 32'h00000080);

    clear_counts();
    run_txn(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 5'd0, 2, -1, 32'h0);
    idle(2, 1'b0);
    chk("sh_be", {28'h0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_wr_cycles", n_wr, 3);
    chk("sh_no_wb", n_wb, 0);

    clear_counts();
    run_txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd1, 0, -1, 32'h0);
    idle(2, 1'b0);
    chk("mis_pulses", n_mis, 1);
    chk("mis_bad_addr", o_bad_addr, 32'h101);
    chk("mis_no_rd", n_rd, 0);
    chk("mis_no_stall", n_stall, 0);

    clear_counts();
    run_txn(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd9, T + 2, -1, 32'h0);
    idle(2, 1'b0);
    chk("to_bus_err", n_berr, 1);
    chk("to_no_wb", n_wb, 0);
    chk("to_rd_cycles", n_rd, T);

    clear_counts();
    run_txn(1, 0, 2'd2, 0, 32'h304, 32'h0, 5'd10, T - 1, -1, 32'h0BADF00D);
    idle(2, 1'b0);
    chk("ack_at_limit_no_err", n_berr, 0);
    chk("ack_at_limit_wb", last_wb, 32'h0BADF00D);

    clear_counts();
    run_txn(1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd11, 10, 4, 32'h0);
    idle(2, 1'b0);
    chk("rst_no_wb", n_wb, 0);
    chk("rst_no_err", n_berr, 0);
    chk("rst_bad_addr", o_bad_addr, 32'h0);

    for (int i = 0; i < 250; i++) begin
      ld  = 1'($urandom);
      st  = ld ? (($urandom % 4) == 0) : 1'b1;
      w   = (($urandom % 8) < 7) ? 2'($urandom % 3) : 2'd3;
      uns = 1'($urandom);
      a   = $urandom;
      if (($urandom % 4) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd2) a[1:0] = 2'b00;
      end
      d  = $urandom_range(0, T + 2);
      ra = (($urandom % 16) == 0) ? $urandom_range(0, (d < T) ? d : T - 1) : -1;
      run_txn(ld, st, w, uns, a, $urandom, 5'($urandom), d, ra, $urandom);
      idle($urandom_range(0, 2), 1'b1);
    end
    idle(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
